// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: per-stage valid/advance handshaking, load-use
// interlock, branch redirect flush, operand forwarding selection and
// stall/flush performance counters for an in-order pipeline.
module pipe_ctrl_unit #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned EXE_IDX    = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fet_valid,
    input  logic [NUM_STAGES-1:0] stage_busy,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_rd_we,
    input  logic                  dec_is_load,
    input  logic                  redirect,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [NUM_STAGES-1:0] stage_adv,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  pc_write_en,
    output logic                  hazard_stall,
    output logic [2:0]            fwd_rs1_sel,
    output logic [2:0]            fwd_rs2_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned NS    = NUM_STAGES;
    localparam int unsigned EX    = EXE_IDX;
    localparam int unsigned SEL_W = 3;

    // Occupancy of stages 1..NS-1; stage 0 occupancy is fet_valid itself
    logic [NS-1:1]         valid_q;
    logic [NS-1:1]         valid_d;

    // Destination scoreboard for the result-producing stages
    logic [REG_ADDR_W-1:0] sb_rd_q [EX:NS-1];
    logic [REG_ADDR_W-1:0] sb_rd_d [EX:NS-1];
    logic [NS-1:EX]        sb_we_q;
    logic [NS-1:EX]        sb_we_d;
    logic [NS-1:EX]        sb_ld_q;
    logic [NS-1:EX]        sb_ld_d;

    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q;
    logic [CNT_W-1:0]      flush_cnt_d;

    // can_acc[NS] stands for the retire port, which always accepts
    logic [NS:1]           can_acc;
    logic [NS-1:0]         adv_raw;
    logic [NS-1:0]         flush_c;
    logic [NS-1:EX]        fwd_cand;
    logic                  hazard_c;
    logic                  redirect_taken;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic [REG_ADDR_W-1:0] exe_rd;

    assign stage_valid = {valid_q, fet_valid};

    // Load-use interlock against the instruction currently in EXE
    assign exe_rd   = sb_rd_q[EX];
    assign rs1_hit  = dec_rs1_used & (dec_rs1 == exe_rd);
    assign rs2_hit  = dec_rs2_used & (dec_rs2 == exe_rd);
    assign hazard_c = stage_valid[1] & stage_valid[EX] & sb_ld_q[EX] & sb_we_q[EX]
                    & (exe_rd != '0) & (rs1_hit | rs2_hit);

    // Back-pressure chain resolved from the last stage toward fetch
    always_comb begin
        can_acc     = '0;
        adv_raw     = '0;
        can_acc[NS] = 1'b1;
        for (int i = int'(NS) - 1; i >= 1; i--) begin
            adv_raw[i] = stage_valid[i] & ~stage_busy[i] & can_acc[i+1];
            if (i == 1) begin
                adv_raw[i] = adv_raw[i] & ~hazard_c;
            end
            can_acc[i] = ~stage_valid[i] | adv_raw[i];
        end
        adv_raw[0] = fet_valid & ~stage_busy[0] & can_acc[1];
    end

    // A branch only resolves once its own instruction actually leaves EXE
    assign redirect_taken = redirect & stage_valid[EX] & adv_raw[EX];

    // Kill every younger stage in front of EXE on a taken redirect
    always_comb begin
        flush_c = '0;
        for (int i = 0; i < int'(EX); i++) begin
            flush_c[i] = redirect_taken;
        end
    end

    assign flush        = flush_c;
    assign stage_adv    = adv_raw & ~flush_c;
    assign hazard_stall = hazard_c;
    assign pc_write_en  = redirect_taken
                        | (fet_valid & ~stage_busy[0] & can_acc[1] & ~hazard_c);

    // Occupancy update: flushed slots empty, accepting slots take the upstream advance
    always_comb begin
        valid_d = valid_q;
        for (int i = 1; i < int'(NS); i++) begin
            if (flush_c[i]) begin
                valid_d[i] = 1'b0;
            end else if (can_acc[i]) begin
                valid_d[i] = stage_adv[i-1];
            end
        end
    end

    // Scoreboard shift; a bubble entering any slot carries rd_we = 0
    always_comb begin
        sb_rd_d = sb_rd_q;
        sb_we_d = sb_we_q;
        sb_ld_d = sb_ld_q;
        if (can_acc[EX]) begin
            sb_rd_d[EX] = dec_rd;
            sb_we_d[EX] = stage_adv[EX-1] & dec_rd_we;
            sb_ld_d[EX] = dec_is_load;
        end
        for (int k = int'(EX) + 1; k < int'(NS); k++) begin
            if (can_acc[k]) begin
                sb_rd_d[k] = sb_rd_q[k-1];
                sb_we_d[k] = stage_adv[k-1] & sb_we_q[k-1];
                sb_ld_d[k] = sb_ld_q[k-1];
            end
        end
    end

    // Stages able to supply a result; a load still in EXE has no data yet
    always_comb begin
        fwd_cand = '0;
        for (int k = int'(EX); k < int'(NS); k++) begin
            fwd_cand[k] = stage_valid[k] & sb_we_q[k] & (sb_rd_q[k] != '0)
                        & ~((k == int'(EX)) & sb_ld_q[k]);
        end
    end

    // Youngest matching producer wins, scanning old-to-young so the lowest index is kept
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        for (int k = int'(NS) - 1; k >= int'(EX); k--) begin
            if (fwd_cand[k] && (sb_rd_q[k] == dec_rs1)) begin
                fwd_rs1_sel = SEL_W'(k);
            end
            if (fwd_cand[k] && (sb_rd_q[k] == dec_rs2)) begin
                fwd_rs2_sel = SEL_W'(k);
            end
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // State registers; reset drops all in-flight instructions at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            sb_we_q     <= '0;
            sb_ld_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int k = int'(EX); k < int'(NS); k++) begin
                sb_rd_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            sb_rd_q     <= sb_rd_d;
            sb_we_q     <= sb_we_d;
            sb_ld_q     <= sb_ld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed pipeline scenarios followed by
// randomized traffic, all compared against an instruction-slot model.
module tb_pipe_ctrl_unit;

    localparam int N    = 5;
    localparam int EX   = 2;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fet_valid;
    logic [N-1:0]  stage_busy;
    logic [RW-1:0] dec_rs1;
    logic [RW-1:0] dec_rs2;
    logic          dec_rs1_used;
    logic          dec_rs2_used;
    logic [RW-1:0] dec_rd;
    logic          dec_rd_we;
    logic          dec_is_load;
    logic          redirect;
    logic [N-1:0]  stage_valid;
    logic [N-1:0]  stage_adv;
    logic [N-1:0]  flush;
    logic          pc_write_en;
    logic          hazard_stall;
    logic [2:0]    fwd_rs1_sel;
    logic [2:0]    fwd_rs2_sel;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    pipe_ctrl_unit #(
        .NUM_STAGES (N),
        .EXE_IDX    (EX),
        .REG_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fet_valid    (fet_valid),
        .stage_busy   (stage_busy),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_rd_we    (dec_rd_we),
        .dec_is_load  (dec_is_load),
        .redirect     (redirect),
        .stage_valid  (stage_valid),
        .stage_adv    (stage_adv),
        .flush        (flush),
        .pc_write_en  (pc_write_en),
        .hazard_stall (hazard_stall),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: one slot record per stage (occupied, destination, writes, is load)
    bit mv  [N];
    bit mwe [N];
    bit mld [N];
    int mrd [N];
    bit nv  [N];
    bit nwe [N];
    bit nld [N];
    int nrd [N];
    int ms;
    int mf;

    bit           go   [N];
    bit           room_at [N];
    bit           kill;
    bit           e_haz;
    bit           e_pc;
    logic [N-1:0] e_valid;
    logic [N-1:0] e_adv;
    logic [N-1:0] e_flush;
    int           e_f1;
    int           e_f2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0; mwe[i] = 0; mld[i] = 0; mrd[i] = 0;
            nv[i] = 0; nwe[i] = 0; nld[i] = 0; nrd[i] = 0;
        end
        ms = 0;
        mf = 0;
    endtask

    // First producer in age order starting at EXE that holds a usable result for rs
    function automatic int fwd_src(input int rs);
        if (rs == 0) return 0;
        for (int k = EX; k < N; k++) begin
            if (mv[k] && mwe[k] && (mrd[k] == rs) && !(k == EX && mld[k])) return k;
        end
        return 0;
    endfunction

    task automatic model_eval();
        bit occ [N];
        bit room;
        bit hit1;
        bit hit2;
        occ[0] = fet_valid;
        for (int i = 1; i < N; i++) occ[i] = mv[i];
        hit1  = dec_rs1_used && (int'(dec_rs1) == mrd[EX]);
        hit2  = dec_rs2_used && (int'(dec_rs2) == mrd[EX]);
        e_haz = occ[1] && occ[EX] && mld[EX] && mwe[EX] && (mrd[EX] != 0) && (hit1 || hit2);
        room = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            go[i]      = occ[i] && !stage_busy[i] && room && !(i == 1 && e_haz);
            room       = !occ[i] || go[i];
            room_at[i] = room;
        end
        kill = redirect && occ[EX] && go[EX];
        for (int i = 0; i < N; i++) begin
            e_valid[i] = occ[i];
            e_flush[i] = kill && (i < EX);
            e_adv[i]   = go[i] && !e_flush[i];
        end
        e_pc = kill || (fet_valid && !stage_busy[0] && room_at[1] && !e_haz);
        e_f1 = fwd_src(int'(dec_rs1));
        e_f2 = fwd_src(int'(dec_rs2));
        for (int i = 0; i < N; i++) begin
            nv[i] = mv[i]; nwe[i] = mwe[i]; nld[i] = mld[i]; nrd[i] = mrd[i];
        end
        for (int i = 1; i < N; i++) begin
            if (kill && i < EX) begin
                nv[i] = 0;
            end else if (room_at[i]) begin
                nv[i] = e_adv[i-1];
                if (i == EX) begin
                    nrd[i] = int'(dec_rd);
                    nwe[i] = e_adv[i-1] && dec_rd_we;
                    nld[i] = dec_is_load;
                end else if (i > EX) begin
                    nrd[i] = mrd[i-1];
                    nwe[i] = e_adv[i-1] && mwe[i-1];
                    nld[i] = mld[i-1];
                end
            end
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                mv[i] = nv[i]; mwe[i] = nwe[i]; mld[i] = nld[i]; mrd[i] = nrd[i];
            end
            if (e_haz && ms < CMAX) ms++;
            if (kill && mf < CMAX) mf++;
        end
    endtask

    task automatic eval_and_check();
        #1;
        model_eval();
        check_eq("stage_valid", 32'(stage_valid), 32'(e_valid));
        check_eq("stage_adv", 32'(stage_adv), 32'(e_adv));
        check_eq("flush", 32'(flush), 32'(e_flush));
        check_eq("pc_write_en", 32'(pc_write_en), 32'(e_pc));
        check_eq("hazard_stall", 32'(hazard_stall), 32'(e_haz));
        check_eq("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e_f1));
        check_eq("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e_f2));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(ms));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(mf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic dec_idle();
        dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = '0; dec_rd_we = 0; dec_is_load = 0;
    endtask

    task automatic drive_random();
        fet_valid = ($urandom_range(0, 99) < 85);
        for (int i = 0; i < N; i++) stage_busy[i] = ($urandom_range(0, 99) < 12);
        dec_rs1      = RW'($urandom_range(0, 3));
        dec_rs2      = RW'($urandom_range(0, 3));
        dec_rs1_used = ($urandom_range(0, 3) != 0);
        dec_rs2_used = ($urandom_range(0, 1) != 0);
        dec_rd       = RW'($urandom_range(0, 3));
        dec_rd_we    = ($urandom_range(0, 3) != 0);
        dec_is_load  = ($urandom_range(0, 1) != 0);
        redirect     = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        fet_valid = 0; stage_busy = '0; redirect = 0;
        dec_idle();
        model_reset();
        @(negedge clk);
        eval_and_check();
        check_eq("reset_valid", 32'(stage_valid[N-1:1]), 32'h0);
        tick();
        rst_n = 1'b1;

        // Steady fetch, no stalls: pipe fills in four cycles then flows every cycle
        fet_valid = 1;
        for (int c = 0; c < 6; c++) begin
            eval_and_check();
            if (c >= 4) begin
                check_eq("fill_valid", 32'(stage_valid), 32'h1f);
                check_eq("fill_adv", 32'(stage_adv), 32'h1f);
                check_eq("fill_pc", 32'(pc_write_en), 32'h1);
            end
            tick();
        end

        // ALU write of x7 forwarded from EXE; x0 never forwarded
        dec_rd = 5'd7; dec_rd_we = 1;
        eval_and_check(); tick();
        dec_idle(); dec_rs2 = 5'd7; dec_rs2_used = 1;
        eval_and_check();
        check_eq("alu_nostall", 32'(hazard_stall), 32'h0);
        check_eq("alu_fwd2", 32'(fwd_rs2_sel), 32'h2);
        tick();
        dec_idle(); dec_rd = 5'd0; dec_rd_we = 1;
        eval_and_check(); tick();
        dec_idle(); dec_rs2 = 5'd0; dec_rs2_used = 1;
        eval_and_check();
        check_eq("x0_fwd2", 32'(fwd_rs2_sel), 32'h0);
        tick();

        // Load x5 followed by a consumer of x5: one bubble, then forward from stage 3
        dec_idle(); dec_rd = 5'd5; dec_rd_we = 1; dec_is_load = 1;
        eval_and_check(); tick();
        dec_idle(); dec_rs1 = 5'd5; dec_rs1_used = 1;
        eval_and_check();
        check_eq("ld_stall", 32'(hazard_stall), 32'h1);
        tick();
        eval_and_check();
        check_eq("ld_bubble", 32'(stage_valid[EX]), 32'h0);
        check_eq("ld_stall_cnt", 32'(stall_cnt), 32'h1);
        check_eq("ld_fwd1", 32'(fwd_rs1_sel), 32'h3);
        check_eq("ld_nostall", 32'(hazard_stall), 32'h0);
        tick();

        // Taken redirect with EXE valid flushes fetch and decode
        dec_idle(); redirect = 1;
        eval_and_check();
        check_eq("redir_flush", 32'(flush), 32'h03);
        check_eq("redir_pc", 32'(pc_write_en), 32'h1);
        tick();
        redirect = 0;
        eval_and_check();
        check_eq("redir_dec_empty", 32'(stage_valid[1]), 32'h0);
        check_eq("redir_flush_cnt", 32'(flush_cnt), 32'h1);
        tick();

        // Randomized traffic with a mid-stream reset
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_random();
            if (cyc == 700) begin
                rst_n = 1'b0;
                model_reset();
                eval_and_check();
                check_eq("midrst_valid", 32'(stage_valid[N-1:1]), 32'h0);
                check_eq("midrst_stall_cnt", 32'(stall_cnt), 32'h0);
                check_eq("midrst_flush_cnt", 32'(flush_cnt), 32'h0);
                tick();
                drive_random();
                eval_and_check();
                tick();
                rst_n = 1'b1;
                drive_random();
            end
            eval_and_check();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of pipeline stages (0=fetch, 1=decode, NUM_STAGES-1=last); legal range 4..8.
REQ-002 SHALL have parameter EXE_IDX, default 2, stage resolving branches and holding load results; legal range 2..NUM_STAGES-2.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, register address width.
REQ-004 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-005 Ports, one clock; reset is asynchronous and active-low:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fet_valid  in  1  fetch stage holds an instruction
- stage_busy  in  NUM_STAGES  stage i needs more cycles (cache miss, multicycle op)
- dec_rs1 / dec_rs2  in  REG_ADDR_W each  decode source registers
- dec_rs1_used / dec_rs2_used  in  1 each  source actually read
- dec_rd  in  REG_ADDR_W  decode destination
- dec_rd_we  in  1  decode writes dec_rd
- dec_is_load  in  1  decode instruction is a load
- redirect  in  1  EXE_IDX instruction is a taken branch/jump
- stage_valid  out  NUM_STAGES  occupancy; bit 0 = fet_valid, bits 1.. registered
- stage_adv  out  NUM_STAGES  instruction in stage i leaves it this cycle
- flush  out  NUM_STAGES  stage i killed this cycle
- pc_write_en  out  1  PC register load enable
- hazard_stall  out  1  load-use bubble this cycle
- fwd_rs1_sel / fwd_rs2_sel  out  3 each  0 = register file, k = result of stage k
- stall_cnt / flush_cnt  out  CNT_W each  performance counters

Function
REQ-006 can_accept[i] SHALL be !stage_valid[i] | stage_adv[i] for i in 1..NUM_STAGES-1.
REQ-007 stage_adv[i] SHALL be stage_valid[i] & !stage_busy[i] & can_accept[i+1]; last stage omits can_accept; decode additionally requires !hazard_stall; all terms combinational, same cycle.
REQ-008 On clock edge stage_valid[i+1] SHALL load stage_adv[i] when can_accept[i+1], else hold; an instruction SHALL never be duplicated or dropped without flush.
REQ-009 hazard_stall SHALL be 1 when stage_valid[1] & stage_valid[EXE_IDX] & EXE is_load & EXE rd_we & EXE rd!=0 & (rs1_used & rs1==rd | rs2_used & rs2==rd).
REQ-010 During hazard_stall, stages 0 and 1 SHALL hold; EXE_IDX SHALL receive a bubble (valid 0) if it advances.
REQ-011 Scoreboard: stages EXE_IDX..NUM_STAGES-1 SHALL register {rd, rd_we, is_load}, shifting with stage_adv; entry into EXE_IDX captures dec_*; bubbles and flushed slots clear rd_we.
REQ-012 redirect_taken SHALL be redirect & stage_valid[EXE_IDX] & stage_adv[EXE_IDX]; redirect otherwise ignored (held by requester).
REQ-013 On redirect_taken, flush[i]=1 for i in 0..EXE_IDX-1, those stage_valid bits cleared next edge, EXE_IDX-1 contents not passed on; redirect overrides hazard_stall and stage_busy of flushed stages.
REQ-014 pc_write_en SHALL be redirect_taken | (fet_valid & !stage_busy[0] & can_accept[1] & !hazard_stall).
REQ-015 fwd_rsX_sel SHALL be lowest k in EXE_IDX..NUM_STAGES-1 with stage_valid[k] & rd_we[k] & rd[k]==dec_rsX & rd[k]!=0, excluding k==EXE_IDX with is_load; else 0; register x0 never forwarded.
REQ-016 stall_cnt SHALL increment each cycle hazard_stall=1; flush_cnt each redirect_taken; both saturate at all-ones.
REQ-017 Simultaneous hazard_stall and redirect_taken: flush wins, stall_cnt still counts that cycle.

Reset
REQ-018 While rst_n=0: stage_valid[NUM_STAGES-1:1]=0, scoreboard rd_we=0, counters=0; all outputs derived from these, no pending redirect kept.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight instructions immediately, no retire pulse after deassertion.

Verification
REQ-020 fet_valid=1 steady, no busy, 5 stages: stage_valid=5'b11111 after 4 cycles, stage_adv all 1, pc_write_en=1 each cycle.
REQ-021 load x5 in EXE, decode rs1=x5 used: hazard_stall=1 one cycle, stage_valid[2]=0 next, stall_cnt=1, then fwd_rs1_sel=3.
REQ-022 ALU writes x7 in EXE, decode rs2=x7: no stall, fwd_rs2_sel=2; with rd=x0 instead: fwd_rs2_sel=0.
REQ-023 redirect with EXE valid: flush=5'b00011, pc_write_en=1, stage_valid[1]=0 next cycle, flush_cnt=1.
REQ-024 stage_busy[3]=1 for 3 cycles, full pipe: stages 0..3 hold 3 cycles, stage 4 retires then empties, no instruction lost.
REQ-025 rst_n low mid-stream then high: stage_valid=0, counters 0, refill from fet_valid only.
